// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core pipeline and a debug/loader port share one
// single-ported data memory. Debug waits at most STARVE_LIMIT core grants.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   core_req/we/addr/wdata    core access request (combinational grant)
//   core_rdata, core_stall    core load data, pipeline hold
//   dbg_req/we/addr/wdata     debug access, held until dbg_ack
//   dbg_rdata, dbg_ack        registered debug read data, completion pulse
//   mem_we/addr/wd, mem_rd    data-memory port (combinational read)
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {IDLE, ACK} state_e;

  localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        dbg_ack_q;
  logic [31:0] dbg_rdata_q;

  logic [4:0]  starve_diff;
  logic        starve_ok;
  logic        gnt_dbg;
  logic        gnt_core;

  // Sign of (count - limit) gives count >= limit without a comparison
  // that degenerates to a constant when the limit is zero.
  assign starve_diff = {1'b0, starve_q} - LIMIT;
  assign starve_ok   = ~starve_diff[4];

  assign gnt_dbg  = (state_q == IDLE) & dbg_req
                  & (~core_req | starve_ok);
  assign gnt_core = core_req & ~gnt_dbg;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt_dbg) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_wd   = dbg_wdata;
    end else if (gnt_core) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_wd   = core_wdata;
    end
    // No write may reach memory while reset is held.
    if (reset) mem_we = 1'b0;
  end

  assign core_rdata = gnt_core ? mem_rd : '0;
  assign core_stall = core_req & ~gnt_core;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_ack    = dbg_ack_q;

  always_comb begin
    starve_d = starve_q;
    if (gnt_dbg || !dbg_req) begin
      starve_d = '0;
    end else if (state_q == IDLE && gnt_core && starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      unique case (state_q)
        IDLE: begin
          dbg_ack_q <= 1'b0;
          if (gnt_dbg) begin
            state_q     <= ACK;
            dbg_ack_q   <= 1'b1;
            dbg_rdata_q <= dbg_we ? 32'd0 : mem_rd;
          end
        end
        ACK: begin
          state_q   <= IDLE;
          dbg_ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
